cnt_seq_monitor: RTL

Downstream consumer of the free-running 4-bit counter stage. Samples the counter value each enabled cycle, checks it against the expected increment-and-wrap sequence, and reports lock, wrap events and sequence errors. It sits directly on the counter's `po_cnt` output and gives the rest of the design a qualified wrap tick plus health status.

---
 rtl/cnt_mon_pkg.sv | 15 +
 rtl/cnt_seq_monitor_sat_cnt.sv | 22 ++
 rtl/cnt_seq_monitor.sv | 103 ++++++++++
 3 files changed

// File: rtl/cnt_mon_pkg.sv
// Shared types and default widths for the counter sequence monitor.
package cnt_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } mon_state_e;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_WRAP_W = 8;
  localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/cnt_seq_monitor_sat_cnt.sv
// Saturating up-counter: holds at all-ones, synchronous clear, async active-low reset.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_monitor.sv
// Checks an upstream counter against its increment-and-wrap sequence and
// reports lock state, qualified wrap ticks and sequence errors.
module cnt_seq_monitor
  import cnt_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WRAP_W = DEF_WRAP_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  pi_cnt,
  input  logic              clr,
  output logic              po_wrap,
  output logic [WRAP_W-1:0] po_wrap_cnt,
  output logic              po_locked,
  output logic              po_err,
  output logic [ERR_W-1:0]  po_err_cnt
);

  mon_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  prev_cnt_reg;
  logic [CNT_W-1:0]  expected;
  logic [WRAP_W-1:0] wrap_cnt_reg;
  logic              wrap_reg;
  logic              err_reg;

  logic is_good, is_zero, is_wrap, is_restart, is_bad;
  logic wrap_hit, err_hit;

  // expected rolls over naturally at CNT_W bits, so max+1 == 0
  assign expected   = prev_cnt_reg + CNT_W'(1);
  assign is_good    = (pi_cnt == expected);
  assign is_zero    = (pi_cnt == '0);
  assign is_wrap    = is_good & is_zero;
  assign is_restart = ~is_good & is_zero;
  assign is_bad     = ~is_good & ~is_zero;

  always_comb begin
    state_next = state_reg;
    wrap_hit   = 1'b0;
    err_hit    = 1'b0;
    if (clr) begin
      state_next = ST_IDLE;
    end else if (en) begin
      case (state_reg)
        ST_IDLE:   state_next = ST_SYNC;
        ST_SYNC: begin
          wrap_hit = is_wrap;
          if (is_wrap) state_next = ST_LOCKED;
        end
        ST_LOCKED: begin
          wrap_hit = is_wrap;
          if (is_restart) begin
            state_next = ST_SYNC;
          end else if (is_bad) begin
            state_next = ST_ERROR;
            err_hit    = 1'b1;
          end
        end
        ST_ERROR:  state_next = ST_SYNC;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      prev_cnt_reg <= '0;
      wrap_cnt_reg <= '0;
      wrap_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      wrap_reg  <= wrap_hit;
      if (clr) begin
        // the sample presented alongside clr is discarded
        wrap_cnt_reg <= '0;
        err_reg      <= 1'b0;
      end else begin
        if (en)       prev_cnt_reg <= pi_cnt;
        if (wrap_hit) wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
        if (err_hit)  err_reg      <= 1'b1;
      end
    end
  end

  sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_hit),
    .cnt (po_err_cnt)
  );

  assign po_wrap     = wrap_reg;
  assign po_wrap_cnt = wrap_cnt_reg;
  assign po_locked   = (state_reg == ST_LOCKED);
  assign po_err      = err_reg;

endmodule
